cache_bank_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one cache bank among 4 requesters (e.g. fetch, load/store, refill, writeback).
- Selects one requester, holds a one-hot grant, pulses a bank start, waits for the bank's done, then releases.
- A watchdog releases the bank if it never completes.
- Sits between the requester ports and the bank datapath.

---
 rtl/cache_bank_arbiter.sv | 126 ++++++++++++
 tb/tb_cache_bank_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bank_arbiter.sv
// Round-robin owner selection and start/done sequencing for one shared cache bank.
// Four requesters; a watchdog releases the bank if done never arrives.
module cache_bank_arbiter #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [3:0] req,
    input  logic       bankDone,
    output logic [3:0] grantOut,
    output logic [1:0] grantIdx,
    output logic       bankStart,
    output logic       busy,
    output logic       timeoutErr
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    localparam bit WDOG_EN = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TLAST =
        TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t               state, state_n;
    logic [TIMEOUT_W-1:0] timer, timer_n;
    logic [1:0]           lastIdx, lastIdx_n;
    logic [3:0]           grantOut_n;
    logic [1:0]           grantIdx_n;
    logic                 bankStart_n;
    logic                 busy_n;
    logic                 timeoutErr_n;

    logic [1:0] win;
    logic [1:0] cand;
    logic       found;

    // Search starts one past the previous owner and wraps.
    always_comb begin
        win   = lastIdx;
        cand  = lastIdx;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = lastIdx + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer;
        lastIdx_n    = lastIdx;
        grantOut_n   = grantOut;
        grantIdx_n   = grantIdx;
        bankStart_n  = 1'b0;
        busy_n       = busy;
        timeoutErr_n = 1'b0;
        unique case (state)
            IDLE: begin
                grantOut_n = 4'b0000;
                grantIdx_n = 2'd0;
                busy_n     = 1'b0;
                if (found) begin
                    state_n    = START;
                    grantIdx_n = win;
                    grantOut_n = 4'b0001 << win;
                    busy_n     = 1'b1;
                end
            end
            START: begin
                bankStart_n = 1'b1;
                timer_n     = '0;
                state_n     = WAIT;
            end
            WAIT: begin
                // Done has priority over a watchdog expiry in the same cycle.
                if (bankDone || (WDOG_EN && timer == TLAST)) begin
                    timeoutErr_n = !bankDone;
                    state_n      = IDLE;
                    grantOut_n   = 4'b0000;
                    grantIdx_n   = 2'd0;
                    busy_n       = 1'b0;
                    lastIdx_n    = grantIdx;
                    timer_n      = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n    = IDLE;
                grantOut_n = 4'b0000;
                grantIdx_n = 2'd0;
                busy_n     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            timer      <= '0;
            lastIdx    <= 2'd3;
            grantOut   <= 4'b0000;
            grantIdx   <= 2'd0;
            bankStart  <= 1'b0;
            busy       <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            lastIdx    <= lastIdx_n;
            grantOut   <= grantOut_n;
            grantIdx   <= grantIdx_n;
            bankStart  <= bankStart_n;
            busy       <= busy_n;
            timeoutErr <= timeoutErr_n;
        end
    end

endmodule

// File: tb/tb_cache_bank_arbiter.sv
// Scoreboard bench for cache_bank_arbiter: directed requests, expected
// grants and release records queued up front, checked by a separate monitor.
module tb_cache_bank_arbiter;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       bankDone = 1'b0;
    logic [3:0] grantOut;
    logic [1:0] grantIdx;
    logic       bankStart;
    logic       busy;
    logic       timeoutErr;

    cache_bank_arbiter #(
        .TIMEOUT_W(8),
        .TIMEOUT  (5)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .req       (req),
        .bankDone  (bankDone),
        .grantOut  (grantOut),
        .grantIdx  (grantIdx),
        .bankStart (bankStart),
        .busy      (busy),
        .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Expected owner per bankStart; expected (timeout flag, cycles) per release.
    int exp_idx[$];
    int exp_to[$];
    int exp_cnt[$];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input int idx, input int to, input int cnt);
        exp_idx.push_back(idx);
        exp_to.push_back(to);
        exp_cnt.push_back(cnt);
    endtask

    task automatic expect_grant(input int idx);
        exp_idx.push_back(idx);
    endtask

    // Monitor
    logic pb = 1'b0;
    logic pbs = 1'b0;
    logic want_start = 1'b0;
    int   cnt = -1;
    int   ei, et, ec;

    always @(negedge clk) begin
        if (!rstN) begin
            pb         = 1'b0;
            pbs        = 1'b0;
            want_start = 1'b0;
            cnt        = -1;
        end else begin
            chk("grant_onehot", int'(grantOut),
                busy ? int'(4'b0001 << grantIdx) : 0);
            if (bankStart && pbs)
                chk("start_single_cycle", 0, 1);
            if (want_start || bankStart)
                chk("start_latency", int'(bankStart), int'(want_start));
            if (bankStart) begin
                if (exp_idx.size() == 0) begin
                    chk("grant_unexpected", int'(grantIdx), -1);
                end else begin
                    ei = exp_idx.pop_front();
                    chk("grant_idx", int'(grantIdx), ei);
                    chk("grant_out", int'(grantOut), 1 << ei);
                end
                cnt = 0;
            end else if (cnt >= 0) begin
                cnt++;
            end
            if (pb && !busy) begin
                if (exp_to.size() == 0) begin
                    chk("release_unexpected", int'(timeoutErr), -1);
                end else begin
                    et = exp_to.pop_front();
                    ec = exp_cnt.pop_front();
                    chk("timeout_err", int'(timeoutErr), et);
                    chk("release_cycles", cnt, ec);
                end
                cnt = -1;
            end else if (timeoutErr) begin
                chk("timeout_without_release", int'(timeoutErr), 0);
            end
            want_start = busy && !pb;
            pb         = busy;
            pbs        = bankStart;
        end
    end

    // Stimulus helpers
    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bankStart) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            chk("bankstart_timeout", 0, 1);
    endtask

    // bankDone high during the d-th cycle after the bankStart cycle.
    task automatic done_after(input int d, input logic [3:0] req_after);
        repeat (d) @(posedge clk);
        #1;
        bankDone = 1'b1;
        req      = req_after;
        @(posedge clk);
        #1;
        bankDone = 1'b0;
    endtask

    task automatic txn(input int d, input logic [3:0] req_after);
        wait_start();
        done_after(d, req_after);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant_out", int'(grantOut), 0);
        chk("rst_grant_idx", int'(grantIdx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_start", int'(bankStart), 0);
        chk("rst_timeout", int'(timeoutErr), 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Round-robin, all requesting, done 2 cycles after each start
        for (int i = 0; i < 5; i++)
            expect_txn(i % 4, 0, 3);
        @(posedge clk);
        #1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++)
            txn(2, 4'b1111);
        txn(2, 4'b0000);
        repeat (3) @(posedge clk);

        // Single request with direct latency checks; owner drops req mid-way
        expect_txn(2, 0, 4);
        #1;
        req = 4'b0100;
        @(negedge clk);
        chk("single_pre_busy", int'(busy), 0);
        @(negedge clk);
        chk("single_grant_out", int'(grantOut), 4);
        chk("single_grant_idx", int'(grantIdx), 2);
        chk("single_busy", int'(busy), 1);
        chk("single_no_start_yet", int'(bankStart), 0);
        @(posedge clk);
        #1;
        req = 4'b0000;
        txn(3, 4'b0000);
        repeat (2) @(posedge clk);

        // Skip and wrap past 3, then next in line
        expect_txn(0, 0, 3);
        expect_txn(1, 0, 3);
        #1;
        req = 4'b0011;
        txn(2, 4'b0011);
        txn(2, 4'b0000);
        repeat (2) @(posedge clk);

        // Watchdog expiry, then requester 1 follows
        expect_txn(0, 1, 5);
        expect_txn(1, 0, 3);
        #1;
        req = 4'b0001;
        wait_start();
        @(posedge clk);
        #1;
        req = 4'b0011;
        txn(2, 4'b0000);
        repeat (2) @(posedge clk);

        // Done lands on the timeout cycle: done wins
        expect_txn(0, 0, 5);
        #1;
        req = 4'b0001;
        txn(4, 4'b0000);
        repeat (2) @(posedge clk);

        // Stray done while idle
        #1;
        bankDone = 1'b1;
        @(posedge clk);
        #1;
        bankDone = 1'b0;
        @(negedge clk);
        chk("stray_idle_busy", int'(busy), 0);
        chk("stray_idle_grant", int'(grantOut), 0);

        // Stray done during START must not end the transaction
        expect_txn(2, 0, 3);
        @(posedge clk);
        #1;
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("stray_start_busy", int'(busy), 1);
        bankDone = 1'b1;
        req      = 4'b0000;
        @(posedge clk);
        #1;
        bankDone = 1'b0;
        txn(2, 4'b0000);
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-WAIT
        expect_grant(2);
        #1;
        req = 4'b0100;
        wait_start();
        req = 4'b0000;
        @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_grant_out", int'(grantOut), 0);
        chk("arst_grant_idx", int'(grantIdx), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_start", int'(bankStart), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // lastIdx back at 3: requester 0 first, then 3
        expect_txn(0, 0, 3);
        expect_txn(3, 0, 3);
        req = 4'b1001;
        txn(2, 4'b1001);
        txn(2, 4'b0000);
        repeat (5) @(negedge clk);

        chk("grant_queue_drained", exp_idx.size(), 0);
        chk("release_queue_drained", exp_to.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
